// File: rtl/keccak_pkg.sv
// Shared Keccak-f constants and lane-indexing helpers used by the rho and pi steps.
package keccak_pkg;

  // Number of lanes in a Keccak-f state (5 x 5 grid).
  localparam int unsigned NumLanes = 32'd25;

  // Rho rotation offsets, indexed by lane index x + 5*y.
  localparam int unsigned RhoOffsets [0:24] = '{
    32'd0,  32'd1,  32'd62, 32'd28, 32'd27,
    32'd36, 32'd44, 32'd6,  32'd55, 32'd20,
    32'd3,  32'd10, 32'd43, 32'd25, 32'd39,
    32'd41, 32'd45, 32'd15, 32'd21, 32'd8,
    32'd18, 32'd2,  32'd61, 32'd56, 32'd14
  };

  // Linear lane index of grid position (x, y); lane 0 sits at the state LSBs.
  function automatic int unsigned lane_idx(input int unsigned x, input int unsigned y);
    return x + 32'd5 * y;
  endfunction

endpackage

// File: rtl/keccak_rotl_lane.sv
// Single-lane left rotate (toward higher bit index) by a compile-time constant.
// Pure wiring: no logic cells, just a re-ordering of the lane bits.
module keccak_rotl_lane #(
  parameter int          LANE_W = 64,
  parameter int unsigned SHIFT  = 32'd0
) (
  input  logic [LANE_W-1:0] lane,
  output logic [LANE_W-1:0] rotated
);

  // A zero shift would produce an empty slice, so it gets its own pass-through branch.
  if (SHIFT == 32'd0) begin : gNoRot
    assign rotated = lane;
  end else begin : gRot
    assign rotated = {lane[LANE_W-1-SHIFT:0], lane[LANE_W-1:LANE_W-SHIFT]};
  end

endmodule

// File: rtl/rho_fun.sv
// Keccak-f rho step: rotates each of the 25 lanes by its fixed offset and
// registers the result for one cycle before it is handed to the pi step.
module rho_fun
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic                  inClk,
  input  logic                  inRstN,
  input  logic                  inValid,
  input  logic [25*LANE_W-1:0]  inData,
  output logic                  outValid,
  output logic [25*LANE_W-1:0]  outData
);

  logic [25*LANE_W-1:0] rotState_s;
  logic [25*LANE_W-1:0] dataReg_r;
  logic                 validReg_r;

  // One constant rotator per lane; offsets reduced modulo the lane width
  // so narrow instances (e.g. Keccak-f[200]) reuse the same table.
  for (genvar y = 0; y < 5; y++) begin : gRow
    for (genvar x = 0; x < 5; x++) begin : gCol
      localparam int unsigned Idx   = lane_idx(x, y);
      localparam int unsigned Shift = RhoOffsets[Idx] % LANE_W;

      keccak_rotl_lane #(
        .LANE_W (LANE_W),
        .SHIFT  (Shift)
      ) uRotl (
        .lane    (inData[LANE_W*Idx +: LANE_W]),
        .rotated (rotState_s[LANE_W*Idx +: LANE_W])
      );
    end
  end

  // Output stage: data loads only on valid input (holds otherwise), valid follows input.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      dataReg_r  <= '0;
      validReg_r <= 1'b0;
    end else begin
      validReg_r <= inValid;
      if (inValid) begin
        dataReg_r <= rotState_s;
      end else begin
        dataReg_r <= dataReg_r;
      end
    end
  end

  assign outData  = dataReg_r;
  assign outValid = validReg_r;

endmodule

// File: tb/tb_rho_fun.sv
// Self-checking bench for rho_fun: a 64-bit-lane instance (Keccak-f[1600])
// and an 8-bit-lane instance (Keccak-f[200]) checked against a bit-level model.
module tb_rho_fun;

  localparam int W64 = 64;
  localparam int W8  = 8;

  // Offsets kept locally so the model does not depend on the design package.
  int unsigned rhoR [0:24] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43,
                               25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  logic                 inClk;
  logic                 inRstN;
  logic                 inValid;
  logic [25*W64-1:0]    inData;
  logic                 outValid;
  logic [25*W64-1:0]    outData;
  logic                 inValid8;
  logic [25*W8-1:0]     inData8;
  logic                 outValid8;
  logic [25*W8-1:0]     outData8;

  int checks = 0;
  int errors = 0;

  rho_fun #(.LANE_W(W64)) dut (
    .inClk    (inClk),
    .inRstN   (inRstN),
    .inValid  (inValid),
    .inData   (inData),
    .outValid (outValid),
    .outData  (outData)
  );

  rho_fun #(.LANE_W(W8)) dut8 (
    .inClk    (inClk),
    .inRstN   (inRstN),
    .inValid  (inValid8),
    .inData   (inData8),
    .outValid (outValid8),
    .outData  (outData8)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  // Reference: input bit z of lane i lands at bit (z + R[i]) mod w of the same lane.
  function automatic logic [1599:0] rhoModel(input logic [1599:0] d, input int w);
    logic [1599:0] o;
    o = '0;
    for (int i = 0; i < 25; i++)
      for (int z = 0; z < w; z++)
        o[w*i + ((z + int'(rhoR[i])) % w)] = d[w*i + z];
    return o;
  endfunction

  function automatic logic [1599:0] randState();
    logic [1599:0] r;
    for (int k = 0; k < 50; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge inClk);
    #1;
  endtask

  initial begin
    logic [1599:0] s0, s1, s2, d, e, expHold;
    logic v;

    // Reset asserted from time 0 with valid, random data on the inputs.
    inRstN   = 1'b0;
    inValid  = 1'b1;
    inData   = randState();
    inValid8 = 1'b1;
    inData8  = inData[199:0];
    #1;
    check("rst_async_valid", 1600'(outValid), 1600'(1'b0));
    check("rst_async_data", 1600'(outData), '0);
    repeat (3) step();
    check("rst_held_valid", 1600'(outValid), 1600'(1'b0));
    check("rst_held_data", 1600'(outData), '0);
    check("rst_held_data8", 1600'(outData8), '0);

    // Release: the first sampled valid appears after the next edge.
    inRstN = 1'b1;
    s0 = randState();
    inData = s0;
    inValid8 = 1'b0;
    step();
    check("first_valid", 1600'(outValid), 1600'(1'b1));
    check("first_data", 1600'(outData), rhoModel(s0, W64));

    // Single-bit walk: bit 0 of lane i must move to bit R[i] of lane i.
    for (int i = 0; i < 25; i++) begin
      inData = '0;
      inData[64*i] = 1'b1;
      e = '0;
      e[64*i + int'(rhoR[i])] = 1'b1;
      step();
      check($sformatf("walk_lane%0d", i), 1600'(outData), e);
    end

    // Wrap-around cases.
    inData = '0;
    inData[64*22 +: 64] = 64'h8000000000000000;
    e = '0;
    e[64*22 +: 64] = 64'h1000000000000000;
    step();
    check("wrap_lane22", 1600'(outData), e);
    inData = '0;
    inData[64*3 +: 64] = 64'hF000000000000000;
    e = '0;
    e[64*3 +: 64] = 64'h000000000F000000;
    step();
    check("wrap_lane3", 1600'(outData), e);

    // Invariants: all ones and all zeros are fixed points.
    inData = '1;
    step();
    check("all_ones", 1600'(outData), {1600{1'b1}});
    inData = '0;
    step();
    check("all_zeros", 1600'(outData), '0);

    // Back-to-back states, then two idle cycles holding the last result.
    s0 = randState();
    s1 = randState();
    s2 = randState();
    inData = s0;
    step();
    check("pipe0", 1600'(outData), rhoModel(s0, W64));
    inData = s1;
    step();
    check("pipe1", 1600'(outData), rhoModel(s1, W64));
    check("pipe1_valid", 1600'(outValid), 1600'(1'b1));
    inData = s2;
    step();
    check("pipe2", 1600'(outData), rhoModel(s2, W64));
    inValid = 1'b0;
    inData = randState();
    for (int k = 0; k < 2; k++) begin
      step();
      check("idle_valid", 1600'(outValid), 1600'(1'b0));
      check("idle_hold", 1600'(outData), rhoModel(s2, W64));
      inData = randState();
    end

    // Random states with random valid gaps: model keeps the last valid result.
    expHold = rhoModel(s2, W64);
    for (int k = 0; k < 1000; k++) begin
      d = randState();
      v = ($urandom_range(0, 7) != 0);
      inData = d;
      inValid = v;
      step();
      if (v) begin
        expHold = rhoModel(d, W64);
        check("rand_popcount", 1600'($countones(outData)), 1600'($countones(d)));
      end
      check("rand_valid", 1600'(outValid), 1600'(v));
      check("rand_data", 1600'(outData), expHold);
    end

    // Reset mid-operation discards the in-flight state without a clock edge.
    inValid = 1'b1;
    inData = randState();
    step();
    #2;
    inRstN = 1'b0;
    #1;
    check("midrst_valid", 1600'(outValid), 1600'(1'b0));
    check("midrst_data", 1600'(outData), '0);
    inRstN = 1'b1;
    inValid = 1'b0;
    step();
    check("postrst_valid", 1600'(outValid), 1600'(1'b0));
    check("postrst_data", 1600'(outData), '0);

    // 8-bit lane instance: offsets reduced modulo 8.
    inData8 = '0;
    inData8[8*2 +: 8] = 8'h01;
    inValid8 = 1'b1;
    e = '0;
    e[8*2 +: 8] = 8'h40;
    step();
    check("w8_lane2", 1600'(outData8), e);
    check("w8_valid", 1600'(outValid8), 1600'(1'b1));
    inData8 = '0;
    inData8[8*16 +: 8] = 8'h01;
    e = '0;
    e[8*16 +: 8] = 8'h20;
    step();
    check("w8_lane16", 1600'(outData8), e);
    for (int k = 0; k < 20; k++) begin
      d = '0;
      d[199:0] = randState();
      inData8 = d[199:0];
      step();
      check("w8_rand", 1600'(outData8), rhoModel(d, W8));
    end
    inValid8 = 1'b0;
    step();
    check("w8_idle_valid", 1600'(outValid8), 1600'(1'b0));
    check("w8_idle_hold", 1600'(outData8), rhoModel(d, W8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
